axi_line_master: RTL
====================

AXI_LINE_MASTER -- requirements
Module: axi_line_master

Interface
REQ-001 BEATS, default 4, beats per line burst, legal range 2..16.
REQ-002 ID, default 0, constant value driven on arid and awid.
REQ-003 aclk  in  1  clock; all state changes on the rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  request present; req_ready  out  1  block idle and accepting.
REQ-006 req_we  in  1  1 = write, 0 = read; req_single  in  1  1 = one 64-bit beat, 0 = full line.
REQ-007 req_addr  in  32  byte address; line requests are aligned to BEATS*8, single requests to 8.
REQ-008 req_wdata  in  64*BEATS  write line, beat k = bits [64k+63:64k]; single writes use beat 0.
REQ-009 req_wstrb  in  8  byte strobe for single writes; line writes always drive 8'hFF.
REQ-010 resp_valid  out  1  one-cycle completion pulse; resp_err  out  1  error flag, valid with resp_valid.
REQ-011 resp_rdata  out  64*BEATS  read line; single read returns in beat 0 with other beats zero; held until next completion.
REQ-012 arvalid out 1, arready in 1, araddr out 32, arlen out 8, arid out 4: AR channel.
REQ-013 rvalid in 1, rready out 1, rdata in 64, rresp in 2, rlast in 1, rid in 4: R channel.
REQ-014 awvalid out 1, awready in 1, awaddr out 32, awlen out 8, awid out 4: AW channel.
REQ-015 wvalid out 1, wready in 1, wdata out 64, wstrb out 8, wlast out 1: W channel.
REQ-016 bvalid in 1, bready out 1, bresp in 2, bid in 4: B channel.
REQ-017 arsize/awsize out 3, fixed at 3'b011; arburst/awburst out 2, fixed at 2'b01 (INCR).

Function
REQ-018 The FSM SHALL have states IDLE, RADDR, RDATA, WRITE, WRESP and DONE; req_ready is 1 only in IDLE.
REQ-019 Acceptance: on req_valid&&req_ready, latch addr, we, single, wdata and wstrb; next state is RADDR for reads, WRITE for writes.
REQ-020 Length: arlen/awlen = 0 when single, BEATS-1 otherwise; araddr/awaddr = latched address.
REQ-021 RADDR: arvalid=1 from the cycle after acceptance; arvalid holds with stable payload until arready; then go to RDATA.
REQ-022 RDATA: rready=1; the beat counter starts at 0; on each rvalid, store rdata into beat[counter] and increment; leave on the beat where counter==arlen.
REQ-023 rlast SHALL be checked: rlast absent on the final beat, or asserted early, sets err; the counter, not rlast, ends the burst.
REQ-024 WRITE: awvalid and wvalid assert in the same cycle; AW and W complete independently; each is tracked by a done flag.
REQ-025 W beats: wdata = beat[wcnt]; wlast = (wcnt==awlen); wcnt advances on wvalid&&wready; wvalid drops after the last beat.
REQ-026 When AW is done and the last W beat is done (same or different cycles), go to WRESP; bready=1 there; on bvalid go to DONE.
REQ-027 err accumulates: any rresp!=0 or bresp!=0 sets err; err clears on acceptance.
REQ-028 DONE: resp_valid=1 and resp_err=err for exactly one cycle, then IDLE; resp_valid is asserted the cycle after the final R or B handshake.
REQ-029 rid/bid are ignored; stray rvalid/bvalid outside RDATA/WRESP see ready=0 and change no state.
REQ-030 Back-to-back: a new request SHALL be accepted in the IDLE cycle that follows DONE; there is no bubble beyond this.

Reset
REQ-031 With aresetn=0 at a clock edge: state=IDLE; counters, flags and err=0; all valid/ready/last outputs=0 except req_ready=1; resp_rdata=0.
REQ-032 Reset mid-burst SHALL abandon the transaction without a resp_valid pulse; the downstream slave is reset alongside.

Verification
REQ-033 Line read 0x80000040, slave returns 0x11..,0x22..,0x33..,0x44.. -> arlen=3; resp_rdata beats 0..3 match; resp_err=0; one resp_valid.
REQ-034 Single write 0x80000008, wstrb=8'h0F, wdata=0xDEADBEEF -> awlen=0; wlast=1 on the first beat; wstrb=0F; resp_valid after bvalid.
REQ-035 Line write with awready delayed 3 cycles and wready toggling -> 4 W beats in order; wlast only on beat 3; single completion.
REQ-036 Read with rresp=2'b10 on beat 1 -> all 4 beats are still consumed; resp_err=1; the next request clears err.
REQ-037 Reset asserted during RDATA beat 2 -> next cycle rready=0, req_ready=1, no resp_valid; the subsequent read completes normally.

Source files
------------

// File: rtl/axi_line_master_if.sv
// AXI4 read/write channel bundle between a line master and its slave.
// 64-bit data, 4-bit IDs; the master drives requests, the slave drives responses.
interface axi_line_master_if;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [3:0]  arid;
   logic [2:0]  arsize;
   logic [1:0]  arburst;

   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;

   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [3:0]  awid;
   logic [2:0]  awsize;
   logic [1:0]  awburst;

   logic        wvalid;
   logic        wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;

   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;

   modport master (
      output arvalid, araddr, arlen, arid, arsize, arburst,
      input  arready,
      input  rvalid, rdata, rresp, rlast, rid,
      output rready,
      output awvalid, awaddr, awlen, awid, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready
   );

   modport slave (
      input  arvalid, araddr, arlen, arid, arsize, arburst,
      output arready,
      output rvalid, rdata, rresp, rlast, rid,
      input  rready,
      input  awvalid, awaddr, awlen, awid, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready
   );
endinterface

// File: rtl/axi_line_master.sv
// Single-outstanding AXI4 master moving one cache line (BEATS x 64 bit) or one
// 64-bit word per request; read data is returned as a whole line on completion.
module axi_line_master #(
   parameter int         BEATS = 4,
   parameter logic [3:0] ID    = 4'd0
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic                  req_single,
   input  logic [31:0]           req_addr,
   input  logic [64*BEATS-1:0]   req_wdata,
   input  logic [7:0]            req_wstrb,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [64*BEATS-1:0]   resp_rdata,
   axi_line_master_if.master     axi
);

   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RADDR = 3'd1;
   localparam logic [2:0] S_RDATA = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_WRESP = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]              state;
   logic [CW-1:0]           cnt;
   logic [7:0]              len_q;
   logic                    aw_done;
   logic                    w_done;
   logic                    err;

   logic [31:0]             addr_q;
   logic                    single_q;
   logic [7:0]              strb_q;
   logic [BEATS-1:0][63:0]  line_q;
   logic [BEATS-1:0][63:0]  line_nxt;

   logic                    accept;
   logic                    last_beat;
   logic                    r_hs;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    unused_ids;

   assign accept    = (state == S_IDLE) && req_valid;
   assign last_beat = ({{(8-CW){1'b0}}, cnt} == len_q);
   assign r_hs      = (state == S_RDATA) && axi.rvalid;
   assign aw_hs     = axi.awvalid && axi.awready;
   assign w_hs      = axi.wvalid && axi.wready;
   assign unused_ids = ^{axi.rid, axi.bid};

   assign req_ready   = (state == S_IDLE);
   assign resp_valid  = (state == S_DONE);
   assign resp_err    = (state == S_DONE) && err;

   assign axi.arvalid = (state == S_RADDR);
   assign axi.araddr  = addr_q;
   assign axi.arlen   = len_q;
   assign axi.arid    = ID;
   assign axi.arsize  = 3'b011;
   assign axi.arburst = 2'b01;
   assign axi.rready  = (state == S_RDATA);

   assign axi.awvalid = (state == S_WRITE) && !aw_done;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = len_q;
   assign axi.awid    = ID;
   assign axi.awsize  = 3'b011;
   assign axi.awburst = 2'b01;

   assign axi.wvalid  = (state == S_WRITE) && !w_done;
   assign axi.wdata   = line_q[cnt];
   assign axi.wstrb   = single_q ? strb_q : 8'hFF;
   assign axi.wlast   = axi.wvalid && last_beat;
   assign axi.bready  = (state == S_WRESP);

   always_comb begin
      line_nxt      = line_q;
      line_nxt[cnt] = axi.rdata;
   end

   // Request payload and line buffer: loaded on acceptance, filled by R beats.
   always_ff @(posedge aclk) begin
      if (accept) begin
         addr_q   <= req_addr;
         single_q <= req_single;
         strb_q   <= req_wstrb;
         line_q   <= req_we ? req_wdata : '0;
      end else if (r_hs) begin
         line_q   <= line_nxt;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         len_q      <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         err        <= 1'b0;
         resp_rdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  state   <= req_we ? S_WRITE : S_RADDR;
                  len_q   <= req_single ? 8'd0 : 8'(BEATS - 1);
                  cnt     <= '0;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  err     <= 1'b0;
               end
            end
            S_RADDR: begin
               if (axi.arready) state <= S_RDATA;
            end
            S_RDATA: begin
               // The beat counter ends the burst; rlast only contributes to err.
               if (axi.rvalid) begin
                  cnt <= cnt + CNT_ONE;
                  if ((axi.rresp != 2'b00) || (axi.rlast != last_beat)) err <= 1'b1;
                  if (last_beat) begin
                     state      <= S_DONE;
                     resp_rdata <= line_nxt;
                  end
               end
            end
            S_WRITE: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs) begin
                  cnt <= cnt + CNT_ONE;
                  if (last_beat) w_done <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || (w_hs && last_beat)))
                  state <= S_WRESP;
            end
            S_WRESP: begin
               if (axi.bvalid) begin
                  if (axi.bresp != 2'b00) err <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
